router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the 1x3 router. Watches the incoming byte stream and the three output FIFOs' status, and generates the load/strobe controls (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg) consumed by router_reg and the FIFO write path. It also produces busy, the back-pressure flag to the packet source. Single-clock, Moore-style, one packet in flight at a time.

## Interface
- No parameters; FIFO count fixed at 3, address width fixed at 2.
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pkt_valid  in  1  source marks header/payload bytes valid; deasserts on parity byte
- data_in  in  2  bits [1:0] of incoming byte (destination address when header)
- fifo_full  in  1  full flag of currently addressed FIFO (muxed externally)
- fifo_empty_0/1/2  in  1 each  empty flags of FIFOs 0..2
- soft_reset_0/1/2  in  1 each  per-FIFO timeout resets from synchronizer
- parity_done  in  1  from router_reg: parity byte captured
- low_pkt_valid  in  1  from router_reg: pkt_valid fell while FIFO was full
- detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state strobes
- write_enb_reg  out  1  router_reg output may be written to FIFO
- rst_int_reg  out  1  router_reg may clear internal parity/error flags
- busy  out  1  source must hold data_in stable
- dest_addr  out  2  latched destination address of current packet

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
- DECODE_ADDRESS: if pkt_valid and data_in!=3: latch dest_addr=data_in; if that FIFO is empty -> LOAD_FIRST_DATA, otherwise -> WAIT_TILL_EMPTY. data_in==3 or !pkt_valid -> stay; dest_addr unchanged.
- WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Abort: soft_reset[dest_addr] high in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next edge. This overrides all other transitions. Soft resets of other FIFOs are ignored.
- Outputs decoded from state only:
  - detect_add=DECODE_ADDRESS
  - lfd_state=LOAD_FIRST_DATA
  - ld_state=LOAD_DATA
  - laf_state=LOAD_AFTER_FULL
  - full_state=FIFO_FULL_STATE
  - rst_int_reg=CHECK_PARITY_ERROR
  - write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL
  - busy=1 in every state except DECODE_ADDRESS and LOAD_DATA

## Timing
- resetn low: state=DECODE_ADDRESS and dest_addr=0 immediately, regardless of clk. Outputs while in reset: detect_add=1, all other outputs 0.
- A reset assertion mid-packet discards the packet; no partial state is retained.
- State register updates on the rising edge; outputs change within the same cycle as the state (no added latency).
- Header accepted on the edge where detect_add=1 and pkt_valid=1; lfd_state is high the following cycle when the destination FIFO is empty.
- Parity byte path: pkt_valid low seen in LOAD_DATA -> LOAD_PARITY for exactly 1 cycle -> CHECK_PARITY_ERROR for exactly 1 cycle.
- Minimum packet occupancy with no stalls: 1 (decode) + 1 (lfd) + N (payload) + 1 (parity) + 1 (check) cycles.

## Structure
- Package router_pkg holds:
  - state enum (3-bit binary encoding, DECODE_ADDRESS=0)
  - address constants ADDR_0..ADDR_2 and ADDR_INVALID=3
- Single module; sub-modules are not warranted. Internally, keep next-state logic, the state/dest_addr registers and the output decode as separate blocks.

## Test plan
- Reset then header 0x16 (addr 2, len 5) with fifo_empty_2=1:
  - states DECODE -> LFD -> LOAD_DATA x5 -> LOAD_PARITY -> CHECK -> DECODE
  - busy low only in DECODE/LOAD_DATA; dest_addr=2
- Header addr 1 with fifo_empty_1=0 for 4 cycles: WAIT_TILL_EMPTY held 4 cycles with busy=1, then LFD on the cycle after empty rises.
- fifo_full pulsed 3 cycles during payload: FIFO_FULL_STATE for 3 cycles -> LAF -> LOAD_DATA; write_enb_reg=0 throughout FIFO_FULL_STATE.
- fifo_full during the last payload byte, low_pkt_valid=1 on exit: FULL -> LAF -> LOAD_PARITY; a second case with parity_done=1 goes LAF -> DECODE.
- Header with data_in=3: remains in DECODE_ADDRESS with dest_addr unchanged. soft_reset_0 during a packet to FIFO 2 has no effect; soft_reset_2 forces DECODE on the next edge.
- resetn dropped asynchronously mid-LOAD_DATA (between edges): detect_add=1 with no clock edge; after release, the next header is accepted normally.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - state encoding and address constants for the router packet sequencer
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    localparam logic [1:0] ADDR_0       = 2'd0;
    localparam logic [1:0] ADDR_1       = 2'd1;
    localparam logic [1:0] ADDR_2       = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    // Pick one of the three per-FIFO flags; the unused address reads as 0.
    function automatic logic sel_fifo(input logic [2:0] flags, input logic [1:0] addr);
        logic r;
        case (addr)
            ADDR_0:  r = flags[0];
            ADDR_1:  r = flags[1];
            ADDR_2:  r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// rtl/router_fsm_if.sv - status inputs and control strobes between router_fsm and its neighbours
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic [1:0] dest_addr;

    modport master (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy, dest_addr
    );

    modport slave (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy, dest_addr
    );
endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - Moore sequencer driving router_reg load strobes and source back-pressure
import router_pkg::*;

module router_fsm (
    input  logic          clk,
    input  logic          resetn,
    router_fsm_if.master  bus
);

    state_e     state_q, state_d;
    logic [1:0] dest_addr_q, dest_addr_d;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;

    assign fifo_empty = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_reset = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= DECODE_ADDRESS;
            dest_addr_q <= ADDR_0;
        end else begin
            state_q     <= state_d;
            dest_addr_q <= dest_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_addr_d = dest_addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
                    dest_addr_d = bus.data_in;
                    state_d     = sel_fifo(fifo_empty, bus.data_in) ? LOAD_FIRST_DATA
                                                                    : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_fifo(fifo_empty, dest_addr_q)) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)      state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A timeout on our own destination FIFO abandons the packet from any state.
        if (state_q != DECODE_ADDRESS && sel_fifo(soft_reset, dest_addr_q))
            state_d = DECODE_ADDRESS;
    end

    always_comb begin
        bus.detect_add    = (state_q == DECODE_ADDRESS);
        bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
        bus.ld_state      = (state_q == LOAD_DATA);
        bus.laf_state     = (state_q == LOAD_AFTER_FULL);
        bus.full_state    = (state_q == FIFO_FULL_STATE);
        bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                         || (state_q == LOAD_AFTER_FULL);
        bus.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
        bus.dest_addr     = dest_addr_q;
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed bench for router_fsm state strobes, stalls, aborts and reset
module tb_router_fsm;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    router_fsm_if rif ();

    router_fsm dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (rif.master)
    );

    always #5 clk = ~clk;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] E_DEC  = 8'b1000_0000;
    localparam logic [7:0] E_LFD  = 8'b0100_0001;
    localparam logic [7:0] E_LD   = 8'b0010_0010;
    localparam logic [7:0] E_WAIT = 8'b0000_0001;
    localparam logic [7:0] E_FULL = 8'b0000_1001;
    localparam logic [7:0] E_LAF  = 8'b0001_0011;
    localparam logic [7:0] E_LP   = 8'b0000_0011;
    localparam logic [7:0] E_CHK  = 8'b0000_0101;

    logic [7:0] obs;
    assign obs = {rif.detect_add, rif.lfd_state, rif.ld_state, rif.laf_state,
                  rif.full_state, rif.rst_int_reg, rif.write_enb_reg, rif.busy};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic st(input string tag, input logic [7:0] exp);
        chk(tag, obs, exp);
    endtask

    task automatic dst(input string tag, input logic [1:0] exp);
        chk(tag, {6'd0, rif.dest_addr}, {6'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn            = 1'b0;
        rif.pkt_valid     = 1'b0;
        rif.data_in       = 2'd0;
        rif.fifo_full     = 1'b0;
        rif.fifo_empty_0  = 1'b0;
        rif.fifo_empty_1  = 1'b0;
        rif.fifo_empty_2  = 1'b0;
        rif.soft_reset_0  = 1'b0;
        rif.soft_reset_1  = 1'b0;
        rif.soft_reset_2  = 1'b0;
        rif.parity_done   = 1'b0;
        rif.low_pkt_valid = 1'b0;
        #3;
        st("reset_outputs", E_DEC);
        dst("reset_dest", 2'd0);
        #5 resetn = 1'b1;
        tick;
        st("idle_after_reset", E_DEC);

        // Packet 1: addr 2, 5 payload bytes, FIFO 2 empty.
        rif.pkt_valid = 1'b1; rif.data_in = 2'd2; rif.fifo_empty_2 = 1'b1;
        tick;
        st("p1_lfd", E_LFD);
        dst("p1_dest", 2'd2);
        rif.data_in = 2'd1;
        tick;
        st("p1_ld1", E_LD);
        for (int i = 2; i <= 5; i++) begin
            tick;
            st($sformatf("p1_ld%0d", i), E_LD);
        end
        rif.pkt_valid = 1'b0;
        tick;
        st("p1_parity", E_LP);
        tick;
        st("p1_check", E_CHK);
        tick;
        st("p1_decode", E_DEC);
        dst("p1_dest_hold", 2'd2);

        // Packet 2: addr 1, FIFO 1 not empty for 4 cycles, then a 3-cycle full stall.
        rif.pkt_valid = 1'b1; rif.data_in = 2'd1; rif.fifo_empty_1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            st($sformatf("p2_wait%0d", i), E_WAIT);
        end
        dst("p2_dest", 2'd1);
        rif.fifo_empty_1 = 1'b1;
        tick;
        st("p2_lfd", E_LFD);
        tick;
        st("p2_ld", E_LD);
        rif.fifo_full = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick;
            st($sformatf("p2_full%0d", i), E_FULL);
            if (i == 3) rif.fifo_full = 1'b0;
        end
        tick;
        st("p2_laf", E_LAF);
        tick;
        st("p2_laf_to_ld", E_LD);
        rif.pkt_valid = 1'b0;
        tick;
        st("p2_parity", E_LP);
        tick;
        st("p2_check", E_CHK);
        rif.fifo_full = 1'b1;
        tick;
        st("p2_check_to_full", E_FULL);
        rif.fifo_full = 1'b0; rif.parity_done = 1'b1;
        tick;
        st("p2_laf2", E_LAF);
        tick;
        st("p2_laf_parity_done", E_DEC);
        rif.parity_done = 1'b0;

        // Packet 3: addr 0, full and pkt_valid fall together on the last byte.
        rif.pkt_valid = 1'b1; rif.data_in = 2'd0; rif.fifo_empty_0 = 1'b1;
        tick;
        st("p3_lfd", E_LFD);
        tick;
        st("p3_ld", E_LD);
        rif.fifo_full = 1'b1; rif.pkt_valid = 1'b0;
        tick;
        st("p3_full_priority", E_FULL);
        rif.fifo_full = 1'b0;
        tick;
        st("p3_laf", E_LAF);
        rif.low_pkt_valid = 1'b1;
        tick;
        st("p3_laf_low_pkt", E_LP);
        rif.low_pkt_valid = 1'b0;
        tick;
        st("p3_check", E_CHK);
        tick;
        st("p3_decode", E_DEC);

        // Invalid address and idle source leave dest_addr alone.
        rif.pkt_valid = 1'b1; rif.data_in = 2'd3;
        tick;
        st("addr3_stay", E_DEC);
        dst("addr3_dest", 2'd0);
        rif.pkt_valid = 1'b0; rif.data_in = 2'd1;
        tick;
        st("novalid_stay", E_DEC);
        dst("novalid_dest", 2'd0);

        // Packet 4: addr 2, foreign soft resets ignored, own soft reset aborts.
        rif.pkt_valid = 1'b1; rif.data_in = 2'd2;
        tick;
        st("p4_lfd", E_LFD);
        rif.soft_reset_0 = 1'b1; rif.soft_reset_1 = 1'b1;
        tick;
        st("p4_sr_other", E_LD);
        rif.soft_reset_0 = 1'b0; rif.soft_reset_1 = 1'b0;
        rif.soft_reset_2 = 1'b1; rif.pkt_valid = 1'b0; rif.fifo_full = 1'b1;
        tick;
        st("p4_sr_own", E_DEC);
        rif.soft_reset_2 = 1'b0; rif.fifo_full = 1'b0;
        tick;
        st("p4_idle", E_DEC);

        // Packet 5: async reset between edges mid-LOAD_DATA.
        rif.pkt_valid = 1'b1; rif.data_in = 2'd2;
        tick;
        st("p5_lfd", E_LFD);
        tick;
        st("p5_ld", E_LD);
        #2 resetn = 1'b0;
        #1;
        st("p5_async_reset", E_DEC);
        dst("p5_async_dest", 2'd0);
        rif.pkt_valid = 1'b0;
        #2 resetn = 1'b1;
        tick;
        st("p5_post_reset", E_DEC);
        rif.pkt_valid = 1'b1; rif.data_in = 2'd1; rif.fifo_empty_1 = 1'b1;
        tick;
        st("p6_lfd", E_LFD);
        dst("p6_dest", 2'd1);
        tick;
        st("p6_ld", E_LD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
